// File: rtl/tdcv2_dline_encoder.sv
// TDCv2 data-line transmitter: round-robin hit words onto two 8b/10b lanes,
// 40-bit frames serialized 8 bits per clk_40 cycle, comma frames when idle.
module tdcv2_dline_encoder #(
    parameter logic [7:0] IDLE_K28_5 = 8'hBC,
    parameter logic [7:0] IDLE_K28_1 = 8'h3C
) (
    input  logic        clk_40,
    input  logic        rst_40,
    input  logic [31:0] hit_data,
    input  logic        hit_valid,
    output logic        hit_ready,
    input  logic        tx_enable,
    input  logic        enable_K28_1,
    input  logic        inject_error_dline1,
    input  logic        inject_error_dline0,
    output logic [7:0]  tdc_dline_1,
    output logic [7:0]  tdc_dline_0,
    output logic [31:0] sent_words_dline1,
    output logic [31:0] sent_words_dline0
);

    logic [2:0]  phase;
    logic        next_lane;
    logic [1:0]  pend_valid;
    logic [31:0] pend [2];
    logic [1:0]  rd;
    logic [1:0]  inj;
    logic [39:0] frame [2];
    logic [7:0]  dline [2];
    logic [31:0] sent [2];
    logic [39:0] enc_frame [2];
    logic [1:0]  enc_rd;
    logic [1:0]  send_data;
    logic [1:0]  inj_pulse;
    logic [7:0]  comma;

    // 5b/6b codes in their RD- form, bit order abcdei (a = MSB)
    function automatic logic [5:0] tbl6(input logic [4:0] x);
        case (x)
            5'd0:  tbl6 = 6'b100111;  5'd1:  tbl6 = 6'b011101;
            5'd2:  tbl6 = 6'b101101;  5'd3:  tbl6 = 6'b110001;
            5'd4:  tbl6 = 6'b110101;  5'd5:  tbl6 = 6'b101001;
            5'd6:  tbl6 = 6'b011001;  5'd7:  tbl6 = 6'b111000;
            5'd8:  tbl6 = 6'b111001;  5'd9:  tbl6 = 6'b100101;
            5'd10: tbl6 = 6'b010101;  5'd11: tbl6 = 6'b110100;
            5'd12: tbl6 = 6'b001101;  5'd13: tbl6 = 6'b101100;
            5'd14: tbl6 = 6'b011100;  5'd15: tbl6 = 6'b010111;
            5'd16: tbl6 = 6'b011011;  5'd17: tbl6 = 6'b100011;
            5'd18: tbl6 = 6'b010011;  5'd19: tbl6 = 6'b110010;
            5'd20: tbl6 = 6'b001011;  5'd21: tbl6 = 6'b101010;
            5'd22: tbl6 = 6'b011010;  5'd23: tbl6 = 6'b111010;
            5'd24: tbl6 = 6'b110011;  5'd25: tbl6 = 6'b100110;
            5'd26: tbl6 = 6'b010110;  5'd27: tbl6 = 6'b110110;
            5'd28: tbl6 = 6'b001110;  5'd29: tbl6 = 6'b101110;
            5'd30: tbl6 = 6'b011110;  default: tbl6 = 6'b101011;
        endcase
    endfunction

    function automatic logic [3:0] tbl4(input logic [2:0] y, input logic alt);
        case (y)
            3'd0:    tbl4 = 4'b1011;
            3'd1:    tbl4 = 4'b1001;
            3'd2:    tbl4 = 4'b0101;
            3'd3:    tbl4 = 4'b1100;
            3'd4:    tbl4 = 4'b1101;
            3'd5:    tbl4 = 4'b1010;
            3'd6:    tbl4 = 4'b0110;
            default: tbl4 = alt ? 4'b0111 : 4'b1110;
        endcase
    endfunction

    // Returns {rd_out, abcdeifghj}; rd = 1 means RD+.
    function automatic logic [10:0] enc_sym(input logic [7:0] b, input logic k, input logic rd_in);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] s6;
        logic [3:0] s4;
        logic       rd6;
        logic       alt;
        x = b[4:0];
        y = b[7:5];
        if (k) begin
            if (b == IDLE_K28_1)
                return {~rd_in, rd_in ? 10'b1100000110 : 10'b0011111001};
            return {~rd_in, rd_in ? 10'b1100000101 : 10'b0011111010};
        end
        // Unbalanced sub-blocks and the neutral D.7 / D.x.3 forms flip under RD+
        s6 = tbl6(x);
        if (rd_in && (($countones(s6) != 3) || (x == 5'd7)))
            s6 = ~s6;
        rd6 = ($countones(s6) == 3) ? rd_in : ~rd_in;
        alt = (y == 3'd7) && ((!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                              (rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
        s4 = tbl4(y, alt);
        if (rd6 && (($countones(s4) != 2) || (y == 3'd3)))
            s4 = ~s4;
        return {(($countones(s4) == 2) ? rd6 : ~rd6), s6, s4};
    endfunction

    function automatic logic [7:0] slice(input logic [39:0] f, input logic [2:0] p);
        case (p)
            3'd0:    slice = f[39:32];
            3'd1:    slice = f[31:24];
            3'd2:    slice = f[23:16];
            3'd3:    slice = f[15:8];
            default: slice = f[7:0];
        endcase
    endfunction

    assign hit_ready         = ~pend_valid[next_lane];
    assign inj_pulse         = {inject_error_dline1, inject_error_dline0};
    assign tdc_dline_0       = dline[0];
    assign tdc_dline_1       = dline[1];
    assign sent_words_dline0 = sent[0];
    assign sent_words_dline1 = sent[1];

    // Next frame per lane: four symbols with disparity chained through them
    always_comb begin
        logic [31:0] w;
        logic [10:0] r;
        logic        rdc;
        logic [39:0] f;
        comma = enable_K28_1 ? IDLE_K28_1 : IDLE_K28_5;
        for (int l = 0; l < 2; l++) begin
            send_data[l] = tx_enable & pend_valid[l];
            w   = pend[l];
            rdc = rd[l];
            f   = '0;
            r   = '0;
            for (int s = 0; s < 4; s++) begin
                r   = enc_sym(send_data[l] ? w[31:24] : comma, ~send_data[l], rdc);
                f   = {f[29:0], r[9:0]};
                rdc = r[10];
                w   = {w[23:0], 8'h00};
            end
            enc_frame[l] = f;
            enc_rd[l]    = rdc;
        end
    end

    always_ff @(posedge clk_40) begin
        if (rst_40) begin
            phase      <= 3'd0;
            next_lane  <= 1'b0;
            pend_valid <= 2'b00;
            rd         <= 2'b00;
            inj        <= 2'b00;
            for (int l = 0; l < 2; l++) begin
                frame[l] <= 40'h0;
                dline[l] <= 8'h00;
                sent[l]  <= 32'h0;
            end
        end else begin
            phase <= (phase == 3'd4) ? 3'd0 : phase + 3'd1;
            for (int l = 0; l < 2; l++)
                dline[l] <= slice(frame[l], phase);
            // Frame boundary: both lanes reload together; RD ignores the injected flip
            if (phase == 3'd4) begin
                for (int l = 0; l < 2; l++) begin
                    frame[l] <= enc_frame[l] ^ {inj[l] | inj_pulse[l], 39'd0};
                    rd[l]    <= enc_rd[l];
                    if (send_data[l]) begin
                        pend_valid[l] <= 1'b0;
                        sent[l]       <= sent[l] + 32'd1;
                    end
                end
                inj <= 2'b00;
            end else begin
                inj <= inj | inj_pulse;
            end
            if (hit_valid && hit_ready) begin
                pend_valid[next_lane] <= 1'b1;
                next_lane             <= ~next_lane;
            end
        end
    end

    always_ff @(posedge clk_40) begin
        if (hit_valid && hit_ready)
            pend[next_lane] <= hit_data;
    end

endmodule

// File: tb/tb_tdcv2_dline_encoder.sv
// Scoreboard bench for tdcv2_dline_encoder: directed stimulus pushes expected
// 40-bit frames per lane, a monitor reassembles serial bytes and compares.
module tb_tdcv2_dline_encoder;

    logic        clk_40 = 1'b0;
    logic        rst_40 = 1'b1;
    logic [31:0] hit_data = 32'h0;
    logic        hit_valid = 1'b0;
    logic        hit_ready;
    logic        tx_enable = 1'b1;
    logic        enable_K28_1 = 1'b0;
    logic        inject_error_dline1 = 1'b0;
    logic        inject_error_dline0 = 1'b0;
    logic [7:0]  tdc_dline_1;
    logic [7:0]  tdc_dline_0;
    logic [31:0] sent_words_dline1;
    logic [31:0] sent_words_dline0;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    logic [39:0] q0[$];
    logic [39:0] q1[$];

    // Hand-encoded frames
    localparam logic [39:0] F_ZERO = 40'h0;
    localparam logic [39:0] F_K5N  = 40'h3EB053EB05;  // K28.5 x4 from RD-
    localparam logic [39:0] F_K5P  = 40'hC14FAC14FA;  // K28.5 x4 from RD+
    localparam logic [39:0] F_K1   = 40'h3E7063E706;  // K28.1 x4 from RD-
    localparam logic [39:0] F_D00  = 40'h9D2749D274;  // 0x00000000
    localparam logic [39:0] F_DFF  = 40'hAC6B1AC6B1;  // 0xFFFFFFFF
    localparam logic [39:0] F_DC5  = 40'hA5A96A5A96;  // 0xC5C5C5C5
    localparam logic [39:0] F_W3   = 40'hC6F14C6D8B;  // 0x03030300 from RD-, ends RD+
    localparam logic [39:0] F_K5P_INJ = 40'h414FAC14FA;
    localparam logic [39:0] F_K5N_INJ = 40'hBEB053EB05;

    tdcv2_dline_encoder dut (
        .clk_40              (clk_40),
        .rst_40              (rst_40),
        .hit_data            (hit_data),
        .hit_valid           (hit_valid),
        .hit_ready           (hit_ready),
        .tx_enable           (tx_enable),
        .enable_K28_1        (enable_K28_1),
        .inject_error_dline1 (inject_error_dline1),
        .inject_error_dline0 (inject_error_dline0),
        .tdc_dline_1         (tdc_dline_1),
        .tdc_dline_0         (tdc_dline_0),
        .sent_words_dline1   (sent_words_dline1),
        .sent_words_dline0   (sent_words_dline0)
    );

    always #5 clk_40 = ~clk_40;

    // Bench-side cycle count; edge_cnt % 5 tracks the frame phase
    always @(posedge clk_40) begin
        if (rst_40) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [39:0] f0, input logic [39:0] f1);
        q0.push_back(f0);
        q1.push_back(f1);
    endtask

    task automatic do_reset();
        rst_40 = 1'b1;
        repeat (2) @(posedge clk_40);
        #1 rst_40 = 1'b0;
    endtask

    task automatic goto_cyc(input int n);
        for (int i = 0; i < 300 && edge_cnt != n; i++) begin
            @(posedge clk_40);
            #1;
        end
        if (edge_cnt != n) begin
            checks++;
            errors++;
            $display("FAIL goto_cyc: at cycle %0d, wanted %0d", edge_cnt, n);
        end
    endtask

    // Monitor: byte k of a frame is on the line in phase (k+1)%5
    initial begin
        logic [39:0] a0, a1;
        int nb, p, fidx;
        logic collecting;
        collecting = 1'b0;
        nb = 0;
        fidx = 0;
        a0 = '0;
        a1 = '0;
        forever begin
            @(negedge clk_40);
            if (rst_40) begin
                collecting = 1'b0;
                nb = 0;
            end else begin
                p = edge_cnt % 5;
                if (p == 1) begin
                    collecting = 1'b1;
                    nb = 0;
                    a0 = '0;
                    a1 = '0;
                end
                if (collecting) begin
                    a0 = {a0[31:0], tdc_dline_0};
                    a1 = {a1[31:0], tdc_dline_1};
                    nb++;
                    if (nb == 5) begin
                        if (q0.size() > 0) chk($sformatf("lane0 frame %0d", fidx), a0, q0.pop_front());
                        if (q1.size() > 0) chk($sformatf("lane1 frame %0d", fidx), a1, q1.pop_front());
                        fidx++;
                        collecting = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset();
        chk("reset hit_ready", hit_ready, 1'b1);
        chk("reset sent0", sent_words_dline0, 32'd0);
        chk("reset sent1", sent_words_dline1, 32'd0);
        chk("reset dline0", tdc_dline_0, 8'h00);

        push(F_ZERO, F_ZERO);
        repeat (3) push(F_K5N, F_K5N);
        repeat (2) push(F_K1, F_K1);
        push(F_D00, F_D00);
        repeat (3) push(F_K5N, F_K5N);
        push(F_DFF, F_DC5);
        push(F_W3, F_K5N);
        repeat (2) push(F_K5P, F_K5N);
        push(F_K5P_INJ, F_K5N);
        push(F_K5P, F_K5N_INJ);

        goto_cyc(15); enable_K28_1 = 1'b1;
        goto_cyc(25); enable_K28_1 = 1'b0;

        goto_cyc(27); chk("ready data w0", hit_ready, 1'b1);
        hit_valid = 1'b1; hit_data = 32'h00000000;
        goto_cyc(28); chk("ready data w1", hit_ready, 1'b1);
        hit_data = 32'h00000000;
        goto_cyc(29); hit_valid = 1'b0;
        goto_cyc(31);
        chk("sent0 after data", sent_words_dline0, 32'd1);
        chk("sent1 after data", sent_words_dline1, 32'd1);

        goto_cyc(35); tx_enable = 1'b0;
        goto_cyc(36); chk("ready bp w1", hit_ready, 1'b1);
        hit_valid = 1'b1; hit_data = 32'hFFFFFFFF;
        goto_cyc(37); chk("ready bp w2", hit_ready, 1'b1);
        hit_data = 32'hC5C5C5C5;
        goto_cyc(38); chk("ready bp full", hit_ready, 1'b0);
        hit_data = 32'h03030300;
        goto_cyc(45); tx_enable = 1'b1;
        goto_cyc(47); chk("ready bp held", hit_ready, 1'b0);
        goto_cyc(49); chk("ready load cycle", hit_ready, 1'b0);
        goto_cyc(50); chk("ready after load", hit_ready, 1'b1);
        goto_cyc(51); hit_valid = 1'b0;
        goto_cyc(56);
        chk("sent0 after bp", sent_words_dline0, 32'd3);
        chk("sent1 after bp", sent_words_dline1, 32'd2);

        goto_cyc(66); inject_error_dline0 = 1'b1;
        goto_cyc(67); inject_error_dline0 = 1'b0;
        goto_cyc(74); inject_error_dline1 = 1'b1;
        goto_cyc(75); inject_error_dline1 = 1'b0;

        goto_cyc(81);
        chk("lane0 queue drained", q0.size(), 40'd0);
        chk("lane1 queue drained", q1.size(), 40'd0);
        goto_cyc(82);
        do_reset();
        chk("midreset hit_ready", hit_ready, 1'b1);
        chk("midreset sent0", sent_words_dline0, 32'd0);
        chk("midreset sent1", sent_words_dline1, 32'd0);

        push(F_ZERO, F_ZERO);
        push(F_K5N, F_K5N);
        push(F_DC5, F_K5N);
        push(F_K5N, F_K5N);

        goto_cyc(4); chk("ready phase4", hit_ready, 1'b1);
        hit_valid = 1'b1; hit_data = 32'hC5C5C5C5;
        goto_cyc(5); hit_valid = 1'b0;
        chk("sent0 not yet loaded", sent_words_dline0, 32'd0);
        goto_cyc(11);
        chk("sent0 phase4 word", sent_words_dline0, 32'd1);
        chk("sent1 phase4 word", sent_words_dline1, 32'd0);

        for (int i = 0; i < 100 && (q0.size() > 0 || q1.size() > 0); i++)
            @(posedge clk_40);
        if (q0.size() > 0 || q1.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL final drain: %0d lane0 and %0d lane1 frames never arrived", q0.size(), q1.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdcv2_dline_encoder.md
Name: tdcv2_dline_encoder

Overview:
Transmit-side counterpart of the TDCv2 data-line receiver. It takes 32-bit TDC hit words and distributes them round-robin over two serial data lines. Each word is 8b/10b encoded with per-lane running disparity, and each 40-bit frame is serialized as 8 bits per clk_40 cycle, which is 320 Mbps per line. It is used as an on-board TDC emulator for loopback and BER testing of the receive chain, and fills idle time with comma frames so the receiver can lock.

Parameters:
IDLE_K28_5, 8'hBC, comma byte used when enable_K28_1=0
IDLE_K28_1, 8'h3C, comma byte used when enable_K28_1=1

Ports:
clk_40  in  1  40 MHz clock
rst_40  in  1  synchronous active-high reset
hit_data  in  32  hit word to transmit
hit_valid  in  1  hit_data valid
hit_ready  out  1  word accepted when hit_valid & hit_ready
tx_enable  in  1  0: pending words are held and only idle frames are sent
enable_K28_1  in  1  idle comma select: 1 = K28.1, 0 = K28.5
inject_error_dline1  in  1  pulse: invert first bit of next frame on lane 1
inject_error_dline0  in  1  pulse: same for lane 0
tdc_dline_1  out  8  lane 1 serial slice, bit 7 earliest
tdc_dline_0  out  8  lane 0 serial slice, bit 7 earliest
sent_words_dline1  out  32  data frames sent on lane 1 (wraps)
sent_words_dline0  out  32  data frames sent on lane 0 (wraps)

Behaviour:
- Reset (synchronous, rst_40=1):
  - phase=0, next_lane=0, both pending registers empty.
  - Both running disparities = RD-, injection latches cleared.
  - Frame registers = 40'h0, tdc_dline_x=8'h00, counters=0, hit_ready=1 on the first cycle after reset.
- Reset mid-frame: the partial frame is abandoned; output is 8'h00 until the first post-reset frame.
- Phase counter 0..4 increments every cycle and wraps 4->0. Both lanes share frame alignment.
- Input handshake:
  - hit_ready = ~pend_valid[next_lane], driven from registers only.
  - On accept, the word is stored in pend[next_lane] and next_lane toggles. First word goes to lane 0.
  - A pending register freed at the phase-4 load cannot be refilled in that same cycle; hit_ready rises the next cycle.
- Frame load at the edge ending phase 4, per lane:
  - If tx_enable=1 and pend valid: encode bytes [31:24],[23:16],[15:8],[7:0] in that order as D-codes. Clear pend, increment sent_words.
  - Otherwise: encode four copies of the comma (K28.5 or K28.1, sampled at load).
  - Encoder: IEEE 802.3 Clause 36 tables. Disparity chains through the four symbols in the load cycle; the final RD is stored for the next frame.
  - Symbol bit order abcdei fghj, 'a' first. Symbol 0 occupies frame[39:30].
  - If the lane's injection latch is set: frame[39] is inverted after encoding. The latch clears, and RD is computed from the un-inverted symbols.
  - Injection pulses are latched on any cycle and held until consumed. A pulse coinciding with the load applies to that load.
- Serialization: on the edge ending phase p, tdc_dline_x <= frame_x[39-8p -: 8] of the current frame. Byte k of a frame is visible in the cycle after phase k.
- Latency: a word accepted in a cycle with phase=q is loaded at the next phase-4 edge. If q=4, the word is not loaded at that edge and waits for the following frame. The word's first byte appears one cycle after the load.
- Lanes are independent except for shared phase and the round-robin pointer. A stalled lane blocks hit_ready only when next_lane points to it.
- tx_enable=0 never drops accepted words. Words are held, and input stalls once both pend registers are full.
- Counters wrap 32'hFFFFFFFF -> 0.

Test Plan:
- Idle K28.5: reset, enable_K28_1=0, no input -> each lane repeats bytes 3E,B0,53,EB,05 every 5 cycles. The frame is K28.5 RD-/RD+ alternating, and RD returns to RD-.
- Idle K28.1: enable_K28_1=1 -> each frame starts 0011111001, alternating RD-/RD+ encodings; receiver model locks.
- Data: after reset idle, send 0x00000000 then 0x00000000 -> lane 0 then lane 1 each emit 9D,27,49,D2,74. sent_words_dline0=1 and sent_words_dline1=1.
- Backpressure: tx_enable=0, offer 3 words -> 2 accepted (lane 0, lane 1), hit_ready=0. Set tx_enable=1 -> both sent at the next load, third word accepted the cycle after, ordering preserved.
- Error injection: pulse inject_error_dline0 during idle -> exactly one lane-0 frame has first byte 0xBE instead of 0x3E. Following frames are correct; lane 1 is unaffected.
- Random traffic: 10^5 random words, random hit_valid, loopback into a reference 8b/10b decoder -> identical word sequence per lane, zero disparity or code errors, counters match.
